// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register with branch/jump redirect and the IF/ID
// pipeline register, including bubble insertion and a valid-fetch counter.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  output logic [31:0] IMemAddress,
  input  logic [31:0] IMemInstruction,
  output logic [31:0] IF_ID_PC4,
  output logic [31:0] IF_ID_Instruction,
  output logic        IF_ID_Valid,
  output logic [31:0] FetchCount
);

  logic [31:0] pc_r;
  logic [31:0] pc4_s;
  logic [31:0] target_s;
  logic [31:0] next_pc_s;
  logic        redirect_s;
  logic        bubble_s;
  logic        load_s;

  logic [31:0] if_id_pc4_r;
  logic [31:0] if_id_instr_r;
  logic        if_id_valid_r;
  logic [31:0] fetch_count_r;

  // Next-PC selection and IF/ID update decision; a branch outranks a jump.
  always_comb begin
    redirect_s = BranchTaken | Jump;
    pc4_s      = pc_r + 32'd4;
    if (BranchTaken) begin
      target_s = BranchTarget & 32'hFFFF_FFFC;
    end else begin
      target_s = JumpTarget & 32'hFFFF_FFFC;
    end
    if (redirect_s) begin
      next_pc_s = target_s;
    end else if (Stall) begin
      next_pc_s = pc_r;
    end else begin
      next_pc_s = pc4_s;
    end
    bubble_s = Flush | redirect_s;
    load_s   = ~bubble_s & ~Stall;
  end

  // Program counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= next_pc_s;
    end
  end

  // IF/ID register and fetch counter; neither bubble nor hold counts as a fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_id_instr_r <= NOP_WORD;
      if_id_pc4_r   <= 32'd0;
      if_id_valid_r <= 1'b0;
      fetch_count_r <= 32'd0;
    end else if (bubble_s) begin
      if_id_instr_r <= NOP_WORD;
      if_id_pc4_r   <= 32'd0;
      if_id_valid_r <= 1'b0;
      fetch_count_r <= fetch_count_r;
    end else if (load_s) begin
      if_id_instr_r <= IMemInstruction;
      if_id_pc4_r   <= pc4_s;
      if_id_valid_r <= 1'b1;
      fetch_count_r <= fetch_count_r + 32'd1;
    end else begin
      if_id_instr_r <= if_id_instr_r;
      if_id_pc4_r   <= if_id_pc4_r;
      if_id_valid_r <= if_id_valid_r;
      fetch_count_r <= fetch_count_r;
    end
  end

  assign IMemAddress       = pc_r;
  assign IF_ID_PC4         = if_id_pc4_r;
  assign IF_ID_Instruction = if_id_instr_r;
  assign IF_ID_Valid       = if_id_valid_r;
  assign FetchCount        = fetch_count_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus random
// control traffic compared against a behavioural fetch-stage model.
module tb_instruction_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = 32'd0;
  logic [31:0] imem_address;
  logic [31:0] imem_instruction;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_instruction;
  logic        if_id_valid;
  logic [31:0] fetch_count;

  logic [31:0] mem [64];
  assign imem_instruction = mem[imem_address[7:2]];

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
  logic        m_valid;
  logic [31:0] saved_cnt;

  instruction_fetch #(.RESET_PC(RST_PC), .NOP_WORD(NOP)) dut (
    .clk(clk), .reset(reset), .Stall(stall), .Flush(flush),
    .BranchTaken(branch_taken), .BranchTarget(branch_target),
    .Jump(jump), .JumpTarget(jump_target),
    .IMemAddress(imem_address), .IMemInstruction(imem_instruction),
    .IF_ID_PC4(if_id_pc4), .IF_ID_Instruction(if_id_instruction),
    .IF_ID_Valid(if_id_valid), .FetchCount(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_instr = NOP; m_pc4 = 32'd0; m_valid = 1'b0; m_cnt = 32'd0;
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, "_pc"}, imem_address, m_pc);
    check_eq({tag, "_instr"}, if_id_instruction, m_instr);
    check_eq({tag, "_pc4"}, if_id_pc4, m_pc4);
    check_eq({tag, "_valid"}, {31'd0, if_id_valid}, {31'd0, m_valid});
    check_eq({tag, "_count"}, fetch_count, m_cnt);
  endtask

  // One clock cycle: apply controls at the falling edge, predict, clock, compare.
  task automatic step(input logic st, input logic fl, input logic bt, input logic [31:0] btgt,
                      input logic jp, input logic [31:0] jtgt);
    logic [31:0] fetched, old_pc, tgt;
    stall = st; flush = fl; branch_taken = bt; branch_target = btgt;
    jump = jp; jump_target = jtgt;
    #1;
    check_eq("imem_addr", imem_address, m_pc);
    old_pc  = m_pc;
    fetched = mem[old_pc[7:2]];
    if (bt || jp) begin
      tgt = bt ? btgt : jtgt;
      m_pc = {tgt[31:2], 2'b00};
    end else if (!st) begin
      m_pc = old_pc + 32'd4;
    end
    if (fl || bt || jp) begin
      m_instr = NOP; m_pc4 = 32'd0; m_valid = 1'b0;
    end else if (!st) begin
      m_instr = fetched; m_pc4 = old_pc + 32'd4; m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
    end
    @(posedge clk);
    @(negedge clk);
    check_all("step");
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h2004_0020;
    mem[1] = 32'h2005_0000;

    // Reset state while reset is held low
    #1;
    model_reset();
    check_all("reset");
    @(negedge clk);
    reset = 1'b1;

    // Sequential fetch from the reset PC
    idle();
    check_eq("seq_instr0", if_id_instruction, 32'h2004_0020);
    check_eq("seq_pc4_0", if_id_pc4, 32'd4);
    idle();
    check_eq("seq_instr1", if_id_instruction, 32'h2005_0000);
    check_eq("seq_pc4_1", if_id_pc4, 32'd8);
    idle();
    check_eq("seq_count", fetch_count, 32'd3);

    // Stall holds PC and IF/ID
    idle(); idle(); idle();
    check_eq("stall_pc_pre", imem_address, 32'h18);
    saved_cnt = fetch_count;
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    check_eq("stall_pc", imem_address, 32'h18);
    check_eq("stall_count", fetch_count, saved_cnt);
    idle();
    check_eq("stall_release_pc", imem_address, 32'h1C);

    // Branch with misaligned target
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h4C);
    saved_cnt = fetch_count;
    step(1'b0, 1'b0, 1'b1, 32'h26, 1'b0, 32'd0);
    check_eq("br_pc", imem_address, 32'h24);
    check_eq("br_valid", {31'd0, if_id_valid}, 32'd0);
    check_eq("br_instr", if_id_instruction, 32'd0);
    check_eq("br_count", fetch_count, saved_cnt);

    // Branch beats jump, redirect beats stall
    step(1'b1, 1'b0, 1'b1, 32'h40, 1'b1, 32'h80);
    check_eq("prio_pc", imem_address, 32'h40);
    check_eq("prio_valid", {31'd0, if_id_valid}, 32'd0);

    // PC+4 wraps at the top of the address space
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC);
    idle();
    check_eq("wrap_pc", imem_address, 32'd0);
    check_eq("wrap_pc4", if_id_pc4, 32'd0);
    check_eq("wrap_valid", {31'd0, if_id_valid}, 32'd1);

    // Stall with flush: hold PC, bubble IF/ID
    step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    check_eq("stfl_pc", imem_address, 32'd0);
    check_eq("stfl_valid", {31'd0, if_id_valid}, 32'd0);

    // Random control traffic
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) == 0, $urandom,
           $urandom_range(0, 9) == 0, $urandom);
    end

    // Asynchronous reset between edges overrides pending controls
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h30);
    check_eq("ar_pc_pre", imem_address, 32'h30);
    stall = 1'b1; flush = 1'b1; branch_taken = 1'b1; branch_target = 32'h100;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    @(negedge clk);
    check_all("rst_held");
    reset = 1'b1;
    idle();
    check_eq("post_rst_instr", if_id_instruction, 32'h2004_0020);
    check_eq("post_rst_pc", imem_address, RST_PC + 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, PC value loaded on reset.
REQ-002 Parameter NOP_WORD, default 32'h00000000, instruction word inserted as a bubble.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 Stall  input  1  hazard-unit request to hold the PC and the IF/ID register.
REQ-006 Flush  input  1  hazard-unit request to replace the IF/ID contents with a bubble.
REQ-007 BranchTaken  input  1  branch resolved taken this cycle.
REQ-008 BranchTarget  input  32  byte address of the branch destination.
REQ-009 Jump  input  1  j/jal/jr redirect this cycle.
REQ-010 JumpTarget  input  32  byte address of the jump destination.
REQ-011 IMemAddress  output  32  fetch address to the instruction memory; equals PC combinationally.
REQ-012 IMemInstruction  input  32  word returned combinationally by the instruction memory for IMemAddress.
REQ-013 IF_ID_PC4  output  32  registered PC+4 of the held instruction.
REQ-014 IF_ID_Instruction  output  32  registered instruction word.
REQ-015 IF_ID_Valid  output  1  1 = IF/ID holds a real instruction; 0 = bubble.
REQ-016 FetchCount  output  32  count of valid instructions loaded into IF/ID.

Function
REQ-017 The PC SHALL be a 32-bit register; IMemAddress SHALL equal PC with zero added latency.
REQ-018 Redirect SHALL be (BranchTaken | Jump); the target SHALL be BranchTarget if BranchTaken=1, else JumpTarget (branch has priority).
REQ-019 The redirect target SHALL be loaded with bits [1:0] forced to 2'b00.
REQ-020 Next-PC priority SHALL be: redirect > Stall (hold PC) > PC+4.
REQ-021 PC+4 SHALL wrap modulo 2^32: 32'hFFFFFFFC advances to 32'h00000000.
REQ-022 IF/ID update priority SHALL be: (Flush | Redirect) -> bubble > Stall -> hold > load.
REQ-023 A bubble SHALL set IF_ID_Instruction=NOP_WORD, IF_ID_PC4=0, and IF_ID_Valid=0.
REQ-024 A load SHALL set IF_ID_Instruction=IMemInstruction, IF_ID_PC4=PC+4, and IF_ID_Valid=1.
REQ-025 Hold SHALL leave all IF/ID outputs and FetchCount unchanged.
REQ-026 FetchCount SHALL increment by 1 on every load, wrap from 32'hFFFFFFFF to 0, and never increment on a bubble or hold.
REQ-027 Simultaneous Stall and Flush without redirect SHALL bubble IF/ID and hold the PC.
REQ-028 Simultaneous Stall and redirect SHALL load the redirect target into the PC and bubble IF/ID.
REQ-029 Load-to-output latency SHALL be one cycle: the word fetched at PC in cycle N SHALL appear on IF_ID_Instruction after edge N+1.
REQ-030 All outputs SHALL be driven from registers, except IMemAddress.

Reset
REQ-031 When reset=0, PC SHALL asynchronously become RESET_PC, IF_ID_Instruction NOP_WORD, IF_ID_PC4 0, IF_ID_Valid 0, and FetchCount 0.
REQ-032 Reset asserted mid-operation SHALL override any pending Stall, Flush or redirect in the same cycle.
REQ-033 On the first rising edge after reset returns to 1 with no control inputs asserted, the word at RESET_PC SHALL be loaded into IF/ID and the PC SHALL become RESET_PC+4.

Verification
REQ-034 Sequential fetch: reset, memory word[0]=32'h20040020 and word[1]=32'h20050000, 3 clocks -> IF/ID shows 32'h20040020 / PC4 4, then 32'h20050000 / PC4 8; FetchCount=3.
REQ-035 Stall: Stall=1 for 2 cycles with PC=0x18 -> PC stays 0x18, IF/ID and FetchCount frozen; after release, PC advances to 0x1C.
REQ-036 Branch: BranchTaken=1, BranchTarget=32'h00000026 at PC=0x4C -> next PC=0x24, IF_ID_Valid=0, IF_ID_Instruction=0, FetchCount unchanged.
REQ-037 Priority: BranchTaken=1 (target 0x40), Jump=1 (target 0x80) and Stall=1 in the same cycle -> next PC=0x40 and IF/ID bubble.
REQ-038 Wrap: force PC=32'hFFFFFFFC, run 1 clock -> PC=0, IF_ID_PC4=0, IF_ID_Valid=1.
REQ-039 Async reset: assert reset between clock edges while PC=0x30 -> PC=RESET_PC, IF_ID_Valid=0 and FetchCount=0 immediately, without waiting for a clock edge.
